// File: rtl/weight_fetch_requester.sv
// Weight SRAM read initiator for one MVMU slice: issues a tile's read beats,
// then reassembles the returned SPEED-byte beats into full rows for crossbar programming.
module weight_fetch_requester #(
  parameter int unsigned SPEED   = 4,
  parameter int unsigned MAX_LEN = 128
) (
  input  logic                     clk,
  input  logic                     RSTn,
  input  logic                     desc_valid,
  output logic                     desc_ready,
  input  logic [31:0]              desc_addr,
  input  logic [15:0]              desc_length,
  input  logic [5:0]               desc_width,
  input  logic [15:0]              desc_jump,
  output logic                     WS_web,
  output logic [31:0]              WS_read_addr,
  output logic [15:0]              WS_length,
  output logic [5:0]               WS_width,
  output logic [15:0]              WS_depth_of_jump,
  input  logic [127:0]             WS_data,
  output logic                     row_valid,
  output logic [MAX_LEN*8-1:0]     row_data,
  output logic [5:0]               row_index,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned CNT_W = 12;
  localparam int unsigned LEN_W = 16;
  localparam int unsigned ROW_W = MAX_LEN * 8;
  localparam int unsigned COL_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   beats_q;
  logic [CNT_W-1:0]   beats_d;
  logic               ws_web_d;
  logic               desc_ready_d;
  logic               err_d;
  logic               start_c;

  logic               legal_c;
  logic [LEN_W-1:0]   beats_per_row_c;
  logic [CNT_W-1:0]   total_beats_c;

  logic               cap_q;
  logic [COL_W-1:0]   col_q;
  logic [5:0]         row_cnt_q;
  logic [COL_W-1:0]   last_col_c;
  logic [ROW_W-1:0]   row_next_c;

  // Descriptor decode, evaluated on the raw inputs so it is ready at the accept edge.
  assign legal_c = (desc_length != '0)
                && ((desc_length % LEN_W'(SPEED)) == '0)
                && (desc_length <= LEN_W'(MAX_LEN))
                && (desc_width != '0);
  assign beats_per_row_c = desc_length / LEN_W'(SPEED);
  assign total_beats_c   = CNT_W'(beats_per_row_c * LEN_W'(desc_width));

  // Request FSM: next state and next values of the registered request outputs.
  always_comb begin
    state_d      = state_q;
    beats_d      = beats_q;
    ws_web_d     = 1'b0;
    err_d        = 1'b0;
    start_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (desc_valid) begin
          if (legal_c) begin
            state_d  = ISSUE;
            beats_d  = total_beats_c;
            ws_web_d = 1'b1;
            start_c  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        beats_d = beats_q - CNT_W'(1);
        if (beats_q == CNT_W'(1)) begin
          state_d = DRAIN;
        end else begin
          ws_web_d = 1'b1;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    desc_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      state_q          <= IDLE;
      beats_q          <= '0;
      WS_web           <= 1'b0;
      desc_ready       <= 1'b1;
      err              <= 1'b0;
      WS_read_addr     <= '0;
      WS_length        <= '0;
      WS_width         <= '0;
      WS_depth_of_jump <= '0;
    end else begin
      state_q    <= state_d;
      beats_q    <= beats_d;
      WS_web     <= ws_web_d;
      desc_ready <= desc_ready_d;
      err        <= err_d;
      if (start_c) begin
        WS_read_addr     <= desc_addr;
        WS_length        <= desc_length;
        WS_width         <= desc_width;
        WS_depth_of_jump <= desc_jump;
      end
    end
  end

  assign last_col_c = COL_W'(WS_length - LEN_W'(SPEED));

  // First beat of a row starts from a cleared buffer so bytes past the row length read as 0.
  always_comb begin
    row_next_c = (col_q == '0) ? '0 : row_data;
    for (int unsigned c = 0; c < MAX_LEN; c++) begin
      for (int unsigned k = 0; k < SPEED; k++) begin
        if (32'(col_q) + k == c) begin
          row_next_c[c*8 +: 8] = WS_data[k*8 +: 8];
        end
      end
    end
  end

  // Capture path: the SRAM returns each beat one cycle after its request.
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      cap_q     <= 1'b0;
      col_q     <= '0;
      row_cnt_q <= '0;
      row_data  <= '0;
      row_valid <= 1'b0;
      row_index <= '0;
      done      <= 1'b0;
    end else begin
      cap_q     <= WS_web;
      row_valid <= 1'b0;
      done      <= 1'b0;
      if (start_c) begin
        col_q     <= '0;
        row_cnt_q <= '0;
      end
      if (cap_q) begin
        row_data <= row_next_c;
        if (col_q == last_col_c) begin
          col_q     <= '0;
          row_cnt_q <= row_cnt_q + 6'd1;
          row_valid <= 1'b1;
          row_index <= row_cnt_q;
          if (row_cnt_q == WS_width - 6'd1) begin
            done <= 1'b1;
          end
        end else begin
          col_q <= col_q + COL_W'(SPEED);
        end
      end
    end
  end

  // Lanes at or above SPEED carry nothing for this slice.
  if (SPEED < 16) begin : g_unused_lanes
    logic unused_lanes;
    assign unused_lanes = ^WS_data[127:SPEED*8];
  end

endmodule

// File: tb/tb_weight_fetch_requester.sv
// Bench for weight_fetch_requester: SRAM stub with mem[a]=a[7:0], table vectors,
// hand-written corner sequences and randomized tiles against a timing/row model.
module tb_weight_fetch_requester;

  localparam int unsigned SPEED   = 4;
  localparam int unsigned MAX_LEN = 128;
  localparam int unsigned ROW_W   = MAX_LEN * 8;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] len;
    logic [5:0]  width;
    logic [15:0] jump;
    bit          bad;
    int          n;
  } desc_t;

  logic              clk = 1'b0;
  logic              RSTn;
  logic              desc_valid;
  logic              desc_ready;
  logic [31:0]       desc_addr;
  logic [15:0]       desc_length;
  logic [5:0]        desc_width;
  logic [15:0]       desc_jump;
  logic              WS_web;
  logic [31:0]       WS_read_addr;
  logic [15:0]       WS_length;
  logic [5:0]        WS_width;
  logic [15:0]       WS_depth_of_jump;
  logic [127:0]      WS_data;
  logic              row_valid;
  logic [ROW_W-1:0]  row_data;
  logic [5:0]        row_index;
  logic              done;
  logic              err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  weight_fetch_requester #(.SPEED(SPEED), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .RSTn(RSTn),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_addr(desc_addr), .desc_length(desc_length),
    .desc_width(desc_width), .desc_jump(desc_jump),
    .WS_web(WS_web), .WS_read_addr(WS_read_addr), .WS_length(WS_length),
    .WS_width(WS_width), .WS_depth_of_jump(WS_depth_of_jump),
    .WS_data(WS_data),
    .row_valid(row_valid), .row_data(row_data), .row_index(row_index),
    .done(done), .err(err)
  );

  // SRAM stub: one-cycle read latency, row/column walk restarts whenever WS_web is low.
  int unsigned sram_beat = 0;
  always @(posedge clk) begin
    int unsigned b;
    int unsigned r;
    int unsigned c;
    logic [31:0] a;
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    if (WS_web) begin
      b = (32'(WS_length) >= SPEED) ? 32'(WS_length) / SPEED : 1;
      r = sram_beat / b;
      c = sram_beat % b;
      a = WS_read_addr + r * 32'(WS_depth_of_jump) + c * SPEED;
      for (int unsigned k = 0; k < SPEED; k++) w[k*8 +: 8] = 8'(a + k);
      sram_beat <= sram_beat + 1;
    end else begin
      sram_beat <= 0;
    end
    WS_data <= w;
  end

  function automatic void chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endfunction

  function automatic void chk_row(input string name, input logic [ROW_W-1:0] act,
                                  input logic [ROW_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      for (int c = 0; c < MAX_LEN; c++) begin
        if (act[c*8 +: 8] !== exp[c*8 +: 8]) begin
          $display("FAIL %s at %0t: byte %0d got %0h want %0h", name, $time, c,
                   act[c*8 +: 8], exp[c*8 +: 8]);
          break;
        end
      end
    end
  endfunction

  function automatic logic [ROW_W-1:0] exp_row(input desc_t d, input int r);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int c = 0; c < MAX_LEN; c++) begin
      if (c < int'(d.len)) v[c*8 +: 8] = 8'(d.addr + 32'(r) * 32'(d.jump) + 32'(c));
    end
    return v;
  endfunction

  function automatic desc_t mk(input logic [31:0] addr, input int len, input int width,
                               input logic [15:0] jump);
    desc_t d;
    d.addr  = addr;
    d.len   = 16'(len);
    d.width = 6'(width);
    d.jump  = jump;
    d.bad   = (len == 0) || (len % SPEED != 0) || (len > MAX_LEN) || (width == 0);
    d.n     = d.bad ? 0 : width * (len / SPEED);
    return d;
  endfunction

  task automatic set_fields(input desc_t d);
    desc_addr   = d.addr;
    desc_length = d.len;
    desc_width  = d.width;
    desc_jump   = d.jump;
  endtask

  // Offers d and returns at the negedge of the cycle after acceptance (T+1), desc_valid still high.
  task automatic drive_desc(input desc_t d);
    int w;
    @(negedge clk);
    set_fields(d);
    desc_valid = 1'b1;
    w = 0;
    while (!desc_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!desc_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: desc_ready got 0 for %0d cycles, want 1", w);
    end
    @(negedge clk);
  endtask

  // Checks cycles T+1..T+kmax of a legal tile; entry and exit on a negedge.
  task automatic check_tile(input desc_t d, input bit scramble, input int kmax);
    int b;
    int r;
    bit ev;
    b = int'(d.len) / SPEED;
    for (int k = 1; k <= kmax; k++) begin
      ev = (k - 2 >= b) && ((k - 2) % b == 0);
      r  = (k - 2) / b - 1;
      chk("ws_web", 80'(WS_web), 80'(k <= d.n));
      chk("row_valid", 80'(row_valid), 80'(ev));
      chk("done", 80'(done), 80'(k == d.n + 2));
      chk("err", 80'(err), 80'(0));
      chk("desc_ready", 80'(desc_ready), 80'(k >= d.n + 2));
      if (WS_web)
        chk("ws_fields", 80'({WS_read_addr, WS_length, WS_width, WS_depth_of_jump}),
            80'({d.addr, d.len, d.width, d.jump}));
      if (ev) begin
        chk("row_index", 80'(row_index), 80'(r));
        chk_row("row_data", row_data, exp_row(d, r));
      end
      if (scramble) begin
        desc_addr   = $urandom;
        desc_length = 16'($urandom);
        desc_width  = 6'($urandom);
        desc_jump   = 16'($urandom);
      end
      if (k < kmax) @(negedge clk);
    end
  endtask

  task automatic run_legal(input desc_t d, input bit scramble);
    drive_desc(d);
    desc_valid = 1'b0;
    check_tile(d, scramble, d.n + 2);
  endtask

  task automatic run_illegal(input desc_t d);
    drive_desc(d);
    desc_valid = 1'b0;
    chk("illegal_err", 80'(err), 80'(1));
    chk("illegal_web", 80'(WS_web), 80'(0));
    chk("illegal_ready", 80'(desc_ready), 80'(1));
    @(negedge clk);
    chk("illegal_err_pulse", 80'(err), 80'(0));
    chk("illegal_web2", 80'(WS_web), 80'(0));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, 80'(desc_ready), 80'(1));
    chk({tag, "_outs"}, 80'({WS_web, row_valid, done, err, row_index}), 80'(0));
    chk({tag, "_ws_fields"}, 80'({WS_read_addr, WS_length, WS_width, WS_depth_of_jump}), 80'(0));
    chk_row({tag, "_row_data"}, row_data, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    desc_t vec[10];
    desc_t d1;
    desc_t d2;
    int seen;

    RSTn = 1'b0;
    desc_valid = 1'b0;
    set_fields(mk(32'h0, 0, 0, 16'h0));
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    RSTn = 1'b1;

    // {addr, length, width, jump} -> expected legality and beat count
    vec[0] = mk(32'h0000_0100, 16, 2, 16'd32);
    vec[1] = mk(32'h0000_0000, 8, 1, 16'd0);
    vec[2] = mk(32'h0000_0040, 6, 1, 16'd8);
    vec[3] = mk(32'h0000_0040, 8, 0, 16'd8);
    vec[4] = mk(32'h0000_0040, 132, 1, 16'd8);
    vec[5] = mk(32'h0000_1000, 128, 1, 16'd0);
    vec[6] = mk(32'h0000_2003, 4, 3, 16'd5);
    vec[7] = mk(32'h0000_0040, 0, 2, 16'd8);
    vec[8] = mk(32'hFFFF_FFF0, 124, 2, 16'd200);
    vec[9] = mk(32'h0000_0777, 12, 63, 16'd12);
    chk("vec0_n", 80'(vec[0].n), 80'(8));
    chk("vec1_n", 80'(vec[1].n), 80'(2));

    for (int i = 0; i < 10; i++) begin
      if (vec[i].bad) run_illegal(vec[i]);
      else            run_legal(vec[i], 1'b0);
    end

    // Back-to-back: second descriptor held on desc_valid throughout the first tile.
    d1 = mk(32'h0000_0200, 16, 1, 16'd0);
    d2 = mk(32'h0000_0300, 8, 2, 16'd64);
    drive_desc(d1);
    set_fields(d2);
    check_tile(d1, 1'b0, d1.n + 2);
    @(negedge clk);
    desc_valid = 1'b0;
    check_tile(d2, 1'b0, d2.n + 2);

    // One-cycle reset in the middle of a width=4 tile, then a fresh tile.
    d1 = mk(32'h0000_0400, 16, 4, 16'd48);
    drive_desc(d1);
    desc_valid = 1'b0;
    check_tile(d1, 1'b0, 7);
    RSTn = 1'b0;
    @(negedge clk);
    check_reset_state("midrst");
    RSTn = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || row_valid || WS_web) seen++;
    end
    chk("no_activity_after_rst", 80'(seen), 80'(0));
    d2 = mk(32'h0000_0500, 16, 4, 16'd48);
    run_legal(d2, 1'b0);

    // Randomized tiles, fields scrambled while busy, with occasional illegal ones.
    for (int i = 0; i < 30; i++) begin
      int len;
      len = int'($urandom_range(0, 34)) * SPEED + (($urandom_range(0, 7) == 0) ? 2 : 0);
      d1 = mk($urandom, len, int'($urandom_range(0, 5)), 16'($urandom));
      if (d1.bad) run_illegal(d1);
      else        run_legal(d1, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
